// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle controller: state encodings,
// opcode/funct constants, ALU op codes and datapath mux selects.
package cpu_defs;

  typedef enum logic [3:0] {
    ST_IF       = 4'd0,
    ST_ID       = 4'd1,
    ST_EX_R     = 4'd2,
    ST_EX_I     = 4'd3,
    ST_EX_LUI   = 4'd4,
    ST_EX_BEQ   = 4'd5,
    ST_EX_J     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_WB_MEM   = 4'd10,
    ST_WB_R     = 4'd11,
    ST_WB_I     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b110;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic       ALUA_PC  = 1'b0;
  localparam logic       ALUA_REG = 1'b1;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic       IORD_PC     = 1'b0;
  localparam logic       IORD_ALUOUT = 1'b1;

  // True when the opcode belongs to the supported instruction subset.
  function automatic logic opcode_defined(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_LUI: ok = 1'b1;
      default:                                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct decoder: ALU operation select plus a legality flag.
module alu_op_decode
  import cpu_defs::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_valid
);

  // Map each supported funct to its ALU op; anything else is illegal.
  always_comb begin
    alu_op      = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_XOR:  alu_op = ALU_XOR;
      default: begin
        alu_op      = ALU_ADD;
        funct_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS-subset control FSM. Datapath controls decode from the
// current state; write enables, instr_done and illegal are held low while
// rst_n is asserted so a reset never lets a partial write escape.
module mc_ctrl_unit
  import cpu_defs::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_re,
  output logic       mem_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [2:0]         dec_alu_op_s;
  logic               funct_valid_s;
  logic               illegal_id_s;
  logic               pc_we_s, ir_we_s, mem_we_s, reg_we_s;
  logic               instr_done_s, illegal_s;

  alu_op_decode u_alu_op_decode (
    .funct       (funct),
    .alu_op      (dec_alu_op_s),
    .funct_valid (funct_valid_s)
  );

  assign illegal_id_s = !opcode_defined(opcode) ||
                        ((opcode == OP_RTYPE) && !funct_valid_s);

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IF: begin
        if (mem_ready) state_d = ST_ID;
        else           state_d = ST_IF;
      end
      ST_ID: begin
        if (illegal_id_s) begin
          state_d = ST_IF;
        end else begin
          case (opcode)
            OP_RTYPE:     state_d = ST_EX_R;
            OP_LW, OP_SW: state_d = ST_MEM_ADDR;
            OP_BEQ:       state_d = ST_EX_BEQ;
            OP_J:         state_d = ST_EX_J;
            OP_ADDI:      state_d = ST_EX_I;
            OP_LUI:       state_d = ST_EX_LUI;
            default:      state_d = ST_IF;
          endcase
        end
      end
      ST_EX_R:     state_d = ST_WB_R;
      ST_EX_I:     state_d = ST_WB_I;
      ST_EX_LUI:   state_d = ST_WB_I;
      ST_MEM_ADDR: begin
        if (opcode == OP_LW) state_d = ST_MEM_RD;
        else                 state_d = ST_MEM_WR;
      end
      ST_MEM_RD: begin
        if (mem_ready) state_d = ST_WB_MEM;
        else           state_d = ST_MEM_RD;
      end
      ST_MEM_WR: begin
        if (mem_ready) state_d = ST_IF;
        else           state_d = ST_MEM_WR;
      end
      default:     state_d = ST_IF;
    endcase
  end

  // State register; async reset parks the FSM in IF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IF;
    else        state_q <= state_d;
  end

  // Per-state control decode.
  always_comb begin
    pc_we_s      = 1'b0;
    pc_src       = PC_SRC_ALU;
    ir_we_s      = 1'b0;
    iord         = IORD_PC;
    mem_re       = 1'b0;
    mem_we_s     = 1'b0;
    reg_we_s     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = ALUA_PC;
    alu_src_b    = ALUB_REG;
    alu_op       = ALU_ADD;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    case (state_q)
      ST_IF: begin
        mem_re    = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_we_s   = mem_ready;
        pc_we_s   = mem_ready;
      end
      ST_ID: begin
        alu_src_b    = ALUB_IMM_SH2;
        illegal_s    = illegal_id_s;
        instr_done_s = illegal_id_s;
      end
      ST_EX_R: begin
        alu_src_a = ALUA_REG;
        alu_op    = dec_alu_op_s;
      end
      ST_EX_I: begin
        alu_src_a = ALUA_REG;
        alu_src_b = ALUB_IMM;
      end
      ST_EX_LUI: begin
        alu_src_b = ALUB_IMM;
        alu_op    = ALU_LUI;
      end
      ST_EX_BEQ: begin
        alu_src_a    = ALUA_REG;
        alu_op       = ALU_SUB;
        pc_src       = PC_SRC_ALUOUT;
        pc_we_s      = zero;
        instr_done_s = 1'b1;
      end
      ST_EX_J: begin
        pc_src       = PC_SRC_JUMP;
        pc_we_s      = 1'b1;
        instr_done_s = 1'b1;
      end
      ST_MEM_ADDR: begin
        alu_src_a = ALUA_REG;
        alu_src_b = ALUB_IMM;
      end
      ST_MEM_RD: begin
        mem_re = 1'b1;
        iord   = IORD_ALUOUT;
      end
      ST_MEM_WR: begin
        mem_we_s     = 1'b1;
        iord         = IORD_ALUOUT;
        instr_done_s = mem_ready;
      end
      ST_WB_R: begin
        reg_we_s     = 1'b1;
        reg_dst      = 1'b1;
        instr_done_s = 1'b1;
      end
      ST_WB_I: begin
        reg_we_s     = 1'b1;
        instr_done_s = 1'b1;
      end
      ST_WB_MEM: begin
        reg_we_s     = 1'b1;
        mem_to_reg   = 1'b1;
        instr_done_s = 1'b1;
      end
      default: begin
        pc_we_s = 1'b0;
      end
    endcase
  end

  assign pc_we      = pc_we_s      & rst_n;
  assign ir_we      = ir_we_s      & rst_n;
  assign mem_we     = mem_we_s     & rst_n;
  assign reg_we     = reg_we_s     & rst_n;
  assign instr_done = instr_done_s & rst_n;
  assign illegal    = illegal_s    & rst_n;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit. A behavioural model expands each
// instruction (opcode, funct, zero, wait counts) into the expected
// per-cycle control vector and mem_ready sequence, then replays it.
module tb_mc_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_we, ir_we, iord, mem_re, mem_we, reg_we, reg_dst;
  logic       mem_to_reg, alu_src_a, instr_done, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q[$];
  logic        rdy_q[$];
  logic [17:0] act;
  logic [17:0] rst_vec;

  mc_ctrl_unit #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
    .iord(iord), .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {pc_we, pc_src, ir_we, iord, mem_re, mem_we, reg_we, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, illegal};

  function automatic logic [17:0] v(input logic pw, input logic [1:0] ps,
      input logic iw, input logic io, input logic mr, input logic mw,
      input logic rw, input logic rd, input logic m2r, input logic sa,
      input logic [1:0] sb, input logic [2:0] op, input logic dn,
      input logic il);
    return {pw, ps, iw, io, mr, mw, rw, rd, m2r, sa, sb, op, dn, il};
  endfunction

  // Spec table for R-type functs: {valid, alu_op}.
  function automatic logic [3:0] ref_rfun(input logic [5:0] fn);
    case (fn)
      6'h20:   return {1'b1, 3'b000};
      6'h22:   return {1'b1, 3'b100};
      6'h24:   return {1'b1, 3'b001};
      6'h25:   return {1'b1, 3'b101};
      6'h26:   return {1'b1, 3'b010};
      default: return {1'b0, 3'b000};
    endcase
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into expected outputs and mem_ready per cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int wif, input int wmem);
    logic [3:0] rf;
    logic       legal;
    rf = ref_rfun(fn);
    legal = (op == 6'h23) || (op == 6'h2b) || (op == 6'h04) || (op == 6'h02) ||
            (op == 6'h08) || (op == 6'h0f) || ((op == 6'h00) && rf[3]);
    for (int i = 0; i < wif; i++) begin
      exp_q.push_back(v(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0));
      rdy_q.push_back(1'b0);
    end
    exp_q.push_back(v(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0));
    rdy_q.push_back(1'b1);
    exp_q.push_back(v(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b000, !legal, !legal));
    rdy_q.push_back(rnd_bit());
    if (legal) begin
      case (op)
        6'h00: begin
          exp_q.push_back(v(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, rf[2:0], 1'b0, 1'b0));
          exp_q.push_back(v(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0));
          rdy_q.push_back(rnd_bit()); rdy_q.push_back(rnd_bit());
        end
        6'h08, 6'h0f: begin
          if (op == 6'h08)
            exp_q.push_back(v(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0));
          else
            exp_q.push_back(v(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b110, 1'b0, 1'b0));
          exp_q.push_back(v(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0));
          rdy_q.push_back(rnd_bit()); rdy_q.push_back(rnd_bit());
        end
        6'h04: begin
          exp_q.push_back(v(z, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b100, 1'b1, 1'b0));
          rdy_q.push_back(rnd_bit());
        end
        6'h02: begin
          exp_q.push_back(v(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0));
          rdy_q.push_back(rnd_bit());
        end
        default: begin
          exp_q.push_back(v(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0));
          rdy_q.push_back(rnd_bit());
          for (int i = 0; i <= wmem; i++) begin
            if (op == 6'h23)
              exp_q.push_back(v(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0));
            else
              exp_q.push_back(v(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, (i == wmem), 1'b0));
            rdy_q.push_back(i == wmem);
          end
          if (op == 6'h23) begin
            exp_q.push_back(v(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0));
            rdy_q.push_back(rnd_bit());
          end
        end
      endcase
    end
  endtask

  // Replay the expected sequence; limit < 0 runs the whole instruction and
  // also checks latency and the single ir_we pulse.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic z, input int limit);
    int n, done_at, irw;
    n = (limit < 0) ? exp_q.size() : limit;
    done_at = -1;
    irw = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      opcode = op; funct = fn; zero = z; mem_ready = rdy_q[i];
      #1;
      checks++;
      if (act !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs %b expected %b", name, i, act, exp_q[i]);
      end
      if (instr_done === 1'b1 && done_at < 0) done_at = i + 1;
      if (ir_we === 1'b1) irw++;
    end
    if (limit < 0) begin
      checks++;
      if (done_at !== n) begin
        errors++;
        $display("FAIL %s latency: instr_done at cycle %0d expected %0d", name, done_at, n);
      end
      checks++;
      if (irw !== 1) begin
        errors++;
        $display("FAIL %s ir_we pulses: %0d expected 1", name, irw);
      end
    end
    exp_q.delete();
    rdy_q.delete();
  endtask

  task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int wif, input int wmem);
    build(op, fn, z, wif, wmem);
    run_instr(name, op, fn, z, -1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (act !== rst_vec) begin
        errors++;
        $display("FAIL reset_outputs: %b expected %b", act, rst_vec);
      end
    end
    release_reset();
  endtask

  task automatic test_add();
    do_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
  endtask

  task automatic test_lw_waits();
    do_instr("lw_wait", 6'h23, 6'h15, 1'b0, 2, 3);
  endtask

  task automatic test_beq();
    do_instr("beq_taken", 6'h04, 6'h3f, 1'b1, 0, 0);
    do_instr("beq_not_taken", 6'h04, 6'h3f, 1'b0, 0, 0);
  endtask

  task automatic test_lui();
    do_instr("lui", 6'h0f, 6'h01, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    do_instr("illegal_op", 6'h3f, 6'h20, 1'b0, 0, 0);
    do_instr("illegal_funct", 6'h00, 6'h00, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_sw();
    build(6'h2b, 6'h00, 1'b0, 0, 5);
    run_instr("sw_pre_reset", 6'h2b, 6'h00, 1'b0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== rst_vec) begin
      errors++;
      $display("FAIL sw_async_reset: %b expected %b", act, rst_vec);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (act !== rst_vec) begin
      errors++;
      $display("FAIL sw_reset_ready: %b expected %b", act, rst_vec);
    end
    @(negedge clk);
    release_reset();
    do_instr("add_after_reset", 6'h00, 6'h22, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [5:0] ops[7];
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0f};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else                            op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
      else                            fn = fns[$urandom_range(0, 4)];
      do_instr($sformatf("rand%0d_op%02h_fn%02h", k, op, fn), op, fn, rnd_bit(),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    rst_vec = v(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0);
    test_reset();
    test_add();
    test_lw_waits();
    test_beq();
    test_lui();
    test_illegal();
    test_reset_mid_sw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_unit.md
# mc_ctrl_unit

Multi-cycle control FSM that sits directly upstream of the 32-bit ALU and drives its 3-bit `ALU_operation` select, operand muxes, register-file, memory, and PC/IR write enables. It sequences one MIPS-subset instruction at a time through fetch, decode, execute, memory, and writeback. It stalls on a memory-ready handshake and consumes the ALU `Zero` flag for branch resolution.

## Interface
Parameters:
- `STATE_W`, 4, width of the state register.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; valid from the ID state onward.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU `Zero` flag.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `pc_we`  out  1  PC write enable.
- `pc_src`  out  2  PC source select: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `ir_we`  out  1  instruction register write enable.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_re`  out  1  memory read request.
- `mem_we`  out  1  memory write request.
- `reg_we`  out  1  register file write enable.
- `reg_dst`  out  1  destination register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  ALU A operand: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `alu_op`  out  3  ALU operation: 000 add, 100 sub, 001 and, 101 or, 010 xor, 110 lui.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction.
- `illegal`  out  1  one-cycle pulse in ID when the opcode/funct combination is undefined.

## Operation
- States: IF, ID, EX_R, EX_I, EX_LUI, EX_BEQ, EX_J, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, WB_R, WB_I.
- Control outputs are decoded combinationally from the current state. Exceptions: `pc_we`/`ir_we` in IF and `pc_we` in EX_BEQ also depend on inputs, as noted below. Outputs not listed for a state are 0.
- **IF**
  - Outputs: `mem_re=1`, `iord=0`, `alu_src_a=0`, `alu_src_b=01`, `alu_op=000`, `pc_src=00`, `ir_we=pc_we=mem_ready`.
  - Stays in IF until `mem_ready`, then goes to ID.
- **ID**
  - Outputs: `alu_src_a=0`, `alu_src_b=11`, `alu_op=000` (branch target into ALUOut).
  - Dispatch on opcode: 000000 → EX_R; 100011/101011 → MEM_ADDR; 000100 → EX_BEQ; 000010 → EX_J; 001000 → EX_I; 001111 → EX_LUI.
  - Undefined opcode, or R-type with undefined funct → `illegal=1`, `instr_done=1`, next state IF.
- **EX_R**: `alu_src_a=1`, `alu_src_b=00`, `alu_op` from funct: 100000→000, 100010→100, 100100→001, 100101→101, 100110→010. Next state WB_R.
- **EX_I**: `alu_src_a=1`, `alu_src_b=10`, `alu_op=000`. Next state WB_I.
- **EX_LUI**: `alu_src_b=10`, `alu_op=110`. Next state WB_I.
- **EX_BEQ**: `alu_src_a=1`, `alu_src_b=00`, `alu_op=100`, `pc_src=01`, `pc_we=zero`, `instr_done=1`. Next state IF.
- **EX_J**: `pc_src=10`, `pc_we=1`, `instr_done=1`. Next state IF.
- **MEM_ADDR**: `alu_src_a=1`, `alu_src_b=10`, `alu_op=000`. lw → MEM_RD; sw → MEM_WR.
- **MEM_RD**: `mem_re=1`, `iord=1`. Holds until `mem_ready`, then goes to WB_MEM.
- **MEM_WR**: `mem_we=1`, `iord=1`, `instr_done=mem_ready`. Holds until `mem_ready`, then goes to IF.
- **WB_R**: `reg_we=1`, `reg_dst=1`, `instr_done=1`. Next state IF.
- **WB_I**: `reg_we=1`, `reg_dst=0`, `instr_done=1`. Next state IF.
- **WB_MEM**: `reg_we=1`, `reg_dst=0`, `mem_to_reg=1`, `instr_done=1`. Next state IF.

## Timing
- Reset: while `rst_n=0`, the state is IF and every write enable (`pc_we`, `ir_we`, `mem_we`, `reg_we`), `instr_done`, and `illegal` is forced to 0. All other outputs take their IF values.
- Reset asserted mid-instruction: abandon the instruction immediately. No partial write is issued after the `rst_n` fall. The first IF begins on the first edge after release.
- Latency with zero memory wait:
  - R-type, addi, lui, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, j: 3 cycles.
  - Illegal instruction: 2 cycles.
- Each cycle with `mem_ready=0` in IF, MEM_RD, or MEM_WR adds exactly one cycle.
- `mem_ready` is sampled only in IF, MEM_RD, and MEM_WR; it is ignored in all other states.
- `mem_re`/`mem_we` stay asserted, with stable `iord`, until the `mem_ready` cycle.
- `zero` is sampled combinationally in EX_BEQ only.

## Structure
- Shared package `cpu_defs`: state encodings, opcode and funct constants, ALU op codes, mux-select constants.
- One sub-module, `alu_op_decode`: combinational funct → {`alu_op`, `funct_valid`}. It is used in both ID (legality check) and EX_R (op select).

## Test plan
- `add` (opcode 0, funct 100000), `mem_ready` tied 1 → states IF,ID,EX_R,WB_R; `alu_op=000` in EX_R; `reg_we=1` and `reg_dst=1` in cycle 4 only; `instr_done` in cycle 4.
- `lw` with `mem_ready=0` for 2 cycles in IF and 3 cycles in MEM_RD → 10 cycles total; `ir_we` pulses exactly once; `mem_to_reg=1` in WB_MEM.
- `beq` with `zero=1`, then `beq` with `zero=0` → `pc_we=1`/`pc_src=01` in cycle 3 of the first; `pc_we=0` in cycle 3 of the second.
- `lui` → `alu_op=110`, `alu_src_b=10` in EX_LUI; WB_I writes rt; 4 cycles.
- Opcode 111111, then R-type with funct 000000 → `illegal` pulses in ID for each; 2 cycles each; no `reg_we`, `mem_we`, or `pc_we` after IF.
- `sw` with `rst_n` pulled low in MEM_WR before `mem_ready` → `mem_we` drops asynchronously; state is IF after release; no `instr_done`.
